// File: rtl/dwc_rd_cmd_pkg.sv
// Shared definitions for the DWC down-converter read-command path:
// default command-field offsets and the pre-decoded side-band record.
package dwc_rd_cmd_pkg;

    localparam int ID_WIDTH_DEF  = 4;
    localparam int ADDR_W_DEF    = 6;
    localparam int MADDR_LSB_DEF = 23;
    localparam int MSIZE_LSB_DEF = 8;
    localparam int SSIZE_LSB_DEF = 11;
    localparam int SMAX_LSB_DEF  = 1;
    // These two sit above the ID field, so the ID width is added at the use site.
    localparam int SCNT_OFS      = 30;
    localparam int FIXED_OFS     = 36;

    // Six ADDR_W fields, the (ADDR_W+1)-bit slave one-hot and the equality flag.
    function automatic int dec_width(input int aw);
        return 7 * aw + 2;
    endfunction

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] mask_mst;
        logic [ADDR_W_DEF-1:0] mask_slv;
        logic                  size_eq;
        logic [ADDR_W_DEF-1:0] maddr_masked;
        logic [ADDR_W_DEF-1:0] second_addr;
        logic [ADDR_W_DEF-1:0] scnt_p1;
        logic [ADDR_W_DEF:0]   slv_one_hot;
        logic [ADDR_W_DEF-1:0] smax_ext;
    } rd_cmd_dec_t;

endpackage

// File: rtl/dwc_rd_cmd_decode.sv
// Combinational pre-decode of one read command word into the side-band
// values the read control FSM needs, packed in rd_cmd_dec_t field order.
module dwc_rd_cmd_decode
    import dwc_rd_cmd_pkg::*;
#(
    parameter int CMD_W     = 37 + ID_WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MADDR_LSB = MADDR_LSB_DEF,
    parameter int MSIZE_LSB = MSIZE_LSB_DEF,
    parameter int SSIZE_LSB = SSIZE_LSB_DEF,
    parameter int SMAX_LSB  = SMAX_LSB_DEF,
    parameter int SCNT_LSB  = SCNT_OFS + ID_WIDTH_DEF,
    parameter int FIXED_BIT = FIXED_OFS + ID_WIDTH_DEF,
    parameter int DEC_W     = dec_width(ADDR_W)
)(
    input  logic [CMD_W-1:0] cmd_word,
    output logic [DEC_W-1:0] cmd_dec
);

    typedef struct packed {
        logic [ADDR_W-1:0] mask_mst;
        logic [ADDR_W-1:0] mask_slv;
        logic              size_eq;
        logic [ADDR_W-1:0] maddr_masked;
        logic [ADDR_W-1:0] second_addr;
        logic [ADDR_W-1:0] scnt_p1;
        logic [ADDR_W:0]   slv_one_hot;
        logic [ADDR_W-1:0] smax_ext;
    } dec_t;

    logic [2:0]        msize;
    logic [2:0]        ssize;
    logic [ADDR_W-1:0] maddr;
    logic [ADDR_W-1:0] smax;
    logic [ADDR_W-1:0] scnt;
    logic              fixed;
    logic [ADDR_W:0]   mst_one_hot;
    logic [ADDR_W:0]   slv_one_hot;
    logic [ADDR_W:0]   mst_low;
    logic [ADDR_W:0]   slv_low;
    logic              unused_cmd_bits;
    dec_t              dec;

    assign msize = cmd_word[MSIZE_LSB +: 3];
    assign ssize = cmd_word[SSIZE_LSB +: 3];
    assign maddr = cmd_word[MADDR_LSB +: ADDR_W];
    assign smax  = cmd_word[SMAX_LSB +: ADDR_W];
    assign scnt  = cmd_word[SCNT_LSB +: ADDR_W];
    assign fixed = cmd_word[FIXED_BIT];

    // Shifts are one bit wider than ADDR_W so a size equal to ADDR_W still
    // yields a correct all-ones low mask before truncation.
    assign mst_one_hot = (ADDR_W+1)'(1) << msize;
    assign slv_one_hot = (ADDR_W+1)'(1) << ssize;
    assign mst_low     = mst_one_hot - (ADDR_W+1)'(1);
    assign slv_low     = slv_one_hot - (ADDR_W+1)'(1);

    always_comb begin
        dec              = '0;
        dec.mask_mst     = ADDR_W'(mst_low & ~slv_low);
        dec.mask_slv     = ADDR_W'(~slv_low);
        dec.size_eq      = (scnt == smax);
        dec.maddr_masked = maddr & ~ADDR_W'(mst_low);
        dec.second_addr  = maddr + ADDR_W'(slv_one_hot);
        dec.scnt_p1      = fixed ? scnt : scnt + ADDR_W'(1);
        dec.slv_one_hot  = slv_one_hot;
        dec.smax_ext     = ADDR_W'({1'b0, smax} << ssize);
    end

    assign cmd_dec = dec;

    // Only the size/address fields matter here; the rest of the word is carried by the queue.
    assign unused_cmd_bits = ^cmd_word;

endmodule

// File: rtl/dwc_downconv_hold_queue_rd.sv
// Read-command holding queue between the show-ahead command FIFO and the
// down-converter read FSM; stores each word with its load-time decode.
module dwc_downconv_hold_queue_rd
    import dwc_rd_cmd_pkg::*;
#(
    parameter int ID_WIDTH            = ID_WIDTH_DEF,
    parameter int CMD_FIFO_DATA_WIDTH = 37 + ID_WIDTH,
    parameter int DEPTH               = 2,
    parameter int ADDR_W              = ADDR_W_DEF,
    parameter int MADDR_LSB           = MADDR_LSB_DEF,
    parameter int MSIZE_LSB           = MSIZE_LSB_DEF,
    parameter int SSIZE_LSB           = SSIZE_LSB_DEF,
    parameter int SMAX_LSB            = SMAX_LSB_DEF,
    parameter int SCNT_LSB            = SCNT_OFS + ID_WIDTH,
    parameter int FIXED_BIT           = FIXED_OFS + ID_WIDTH
)(
    input  logic                             ACLK,
    input  logic                             sysReset,
    input  logic [CMD_FIFO_DATA_WIDTH-1:0]   hold_data_in,
    input  logic                             hold_fifo_empty,
    input  logic                             hold_get_next_data,
    input  logic                             flush,
    output logic                             hold_fifo_rd_en,
    output logic [CMD_FIFO_DATA_WIDTH-1:0]   hold_data_out,
    output logic                             hold_reg_empty,
    output logic [$clog2(DEPTH+1)-1:0]       hold_count,
    output logic [ADDR_W-1:0]                mask_mstSize,
    output logic [ADDR_W-1:0]                mask_slvSize,
    output logic                             sizeCnt_comb_EQ_SizeMax,
    output logic [ADDR_W-1:0]                master_ADDR_masked,
    output logic [ADDR_W-1:0]                second_Beat_Addr,
    output logic [ADDR_W-1:0]                sizeCnt_comb_P1,
    output logic [ADDR_W:0]                  slaveSize_one_hot_hold,
    output logic [ADDR_W-1:0]                sizeMax_extend
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DEC_W = dec_width(ADDR_W);

    typedef struct packed {
        logic [ADDR_W-1:0] mask_mst;
        logic [ADDR_W-1:0] mask_slv;
        logic              size_eq;
        logic [ADDR_W-1:0] maddr_masked;
        logic [ADDR_W-1:0] second_addr;
        logic [ADDR_W-1:0] scnt_p1;
        logic [ADDR_W:0]   slv_one_hot;
        logic [ADDR_W-1:0] smax_ext;
    } dec_t;

    logic [CMD_FIFO_DATA_WIDTH-1:0] word_mem [DEPTH];
    logic [DEC_W-1:0]               dec_mem  [DEPTH];
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [CNT_W-1:0]               count;
    logic [CMD_FIFO_DATA_WIDTH-1:0] head_word;
    logic [CMD_FIFO_DATA_WIDTH-1:0] head_word_nxt;
    dec_t                           head_dec;
    dec_t                           head_dec_nxt;
    logic [DEC_W-1:0]               dec_in;
    logic                           push;
    logic                           pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    dwc_rd_cmd_decode #(
        .CMD_W     (CMD_FIFO_DATA_WIDTH),
        .ADDR_W    (ADDR_W),
        .MADDR_LSB (MADDR_LSB),
        .MSIZE_LSB (MSIZE_LSB),
        .SSIZE_LSB (SSIZE_LSB),
        .SMAX_LSB  (SMAX_LSB),
        .SCNT_LSB  (SCNT_LSB),
        .FIXED_BIT (FIXED_BIT),
        .DEC_W     (DEC_W)
    ) u_decode (
        .cmd_word (hold_data_in),
        .cmd_dec  (dec_in)
    );

    // A pop frees a slot in the same cycle, so a full queue can still refill
    // while draining and back-to-back bursts see no bubble.
    assign pop             = hold_get_next_data & (count != '0) & ~flush;
    assign hold_fifo_rd_en = sysReset & ~hold_fifo_empty & ~flush
                             & ((count < CNT_W'(DEPTH)) | pop);
    assign push            = hold_fifo_rd_en;

    // Head registers keep the last popped command when the queue drains.
    always_comb begin
        head_word_nxt = head_word;
        head_dec_nxt  = head_dec;
        if (!flush) begin
            if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
                head_word_nxt = hold_data_in;
                head_dec_nxt  = dec_in;
            end else if (pop && (count > CNT_W'(1))) begin
                head_word_nxt = word_mem[ptr_inc(rd_ptr)];
                head_dec_nxt  = dec_mem[ptr_inc(rd_ptr)];
            end
        end
    end

    always_ff @(posedge ACLK or negedge sysReset) begin
        if (!sysReset) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_word <= '0;
            head_dec  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                dec_mem[i]  <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                word_mem[wr_ptr] <= hold_data_in;
                dec_mem[wr_ptr]  <= dec_in;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            head_word <= head_word_nxt;
            head_dec  <= head_dec_nxt;
        end
    end

    always @(posedge ACLK) begin
        if (sysReset) begin
            assert (count <= CNT_W'(DEPTH));
        end
    end

    assign hold_data_out           = head_word;
    assign hold_reg_empty          = (count == '0);
    assign hold_count              = count;
    assign mask_mstSize            = head_dec.mask_mst;
    assign mask_slvSize            = head_dec.mask_slv;
    assign sizeCnt_comb_EQ_SizeMax = head_dec.size_eq;
    assign master_ADDR_masked      = head_dec.maddr_masked;
    assign second_Beat_Addr        = head_dec.second_addr;
    assign sizeCnt_comb_P1         = head_dec.scnt_p1;
    assign slaveSize_one_hot_hold  = head_dec.slv_one_hot;
    assign sizeMax_extend          = head_dec.smax_ext;

endmodule

// File: tb/tb_dwc_downconv_hold_queue_rd.sv
// Directed bench for the read-command hold queue: a DEPTH=2 instance for the
// main scenarios and a DEPTH=1 instance for single-register behaviour.
module tb_dwc_downconv_hold_queue_rd;

    localparam int CW = 41;
    localparam int AW = 6;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic sysReset;

    logic [CW-1:0] fifo_mem [0:31];
    int            fidx_a = 0;
    int            fidx_b = 0;

    logic          force_a, get_a, flush_a;
    logic [CW-1:0] data_a, out_a;
    logic          rd_en_a, regempty_a, eq_a;
    logic [1:0]    count_a;
    logic [AW-1:0] mst_a, slv_a, masked_a, second_a, p1_a, smaxe_a;
    logic [AW:0]   onehot_a;

    logic          force_b, get_b, flush_b;
    logic [CW-1:0] data_b, out_b;
    logic          rd_en_b, regempty_b, eq_b;
    logic [0:0]    count_b;
    logic [AW-1:0] mst_b, slv_b, masked_b, second_b, p1_b, smaxe_b;
    logic [AW:0]   onehot_b;

    int n_chk  = 0;
    int n_fail = 0;

    assign data_a = fifo_mem[fidx_a];
    assign data_b = fifo_mem[fidx_b];

    always @(posedge ACLK) if (rd_en_a) fidx_a <= fidx_a + 1;
    always @(posedge ACLK) if (rd_en_b) fidx_b <= fidx_b + 1;

    dwc_downconv_hold_queue_rd #(.DEPTH(2)) dut_a (
        .ACLK(ACLK), .sysReset(sysReset),
        .hold_data_in(data_a), .hold_fifo_empty(force_a),
        .hold_get_next_data(get_a), .flush(flush_a),
        .hold_fifo_rd_en(rd_en_a), .hold_data_out(out_a),
        .hold_reg_empty(regempty_a), .hold_count(count_a),
        .mask_mstSize(mst_a), .mask_slvSize(slv_a),
        .sizeCnt_comb_EQ_SizeMax(eq_a), .master_ADDR_masked(masked_a),
        .second_Beat_Addr(second_a), .sizeCnt_comb_P1(p1_a),
        .slaveSize_one_hot_hold(onehot_a), .sizeMax_extend(smaxe_a)
    );

    dwc_downconv_hold_queue_rd #(.DEPTH(1)) dut_b (
        .ACLK(ACLK), .sysReset(sysReset),
        .hold_data_in(data_b), .hold_fifo_empty(force_b),
        .hold_get_next_data(get_b), .flush(flush_b),
        .hold_fifo_rd_en(rd_en_b), .hold_data_out(out_b),
        .hold_reg_empty(regempty_b), .hold_count(count_b),
        .mask_mstSize(mst_b), .mask_slvSize(slv_b),
        .sizeCnt_comb_EQ_SizeMax(eq_b), .master_ADDR_masked(masked_b),
        .second_Beat_Addr(second_b), .sizeCnt_comb_P1(p1_b),
        .slaveSize_one_hot_hold(onehot_b), .sizeMax_extend(smaxe_b)
    );

    function automatic logic [CW-1:0] make_cmd(input logic [5:0] maddr, input logic [2:0] msize,
                                               input logic [2:0] ssize, input logic [5:0] smax,
                                               input logic [5:0] scnt, input logic fixed,
                                               input logic [8:0] tag);
        logic [CW-1:0] w;
        w          = '0;
        w[23 +: 6] = maddr;
        w[8 +: 3]  = msize;
        w[11 +: 3] = ssize;
        w[1 +: 6]  = smax;
        w[34 +: 6] = scnt;
        w[40]      = fixed;
        w[14 +: 9] = tag;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sysReset = 1'b1;
        force_a = 1'b1; get_a = 1'b0; flush_a = 1'b0;
        force_b = 1'b1; get_b = 1'b0; flush_b = 1'b0;
        for (int i = 0; i < 32; i++)
            fifo_mem[i] = make_cmd(6'(i * 3), 3'd3, 3'd1, 6'd0, 6'(i), 1'b0, 9'(9'h100 | i));
        fifo_mem[0]  = make_cmd(6'h13, 3'd5, 3'd2, 6'h07, 6'h07, 1'b0, 9'h000);
        fifo_mem[1]  = make_cmd(6'h13, 3'd5, 3'd2, 6'h07, 6'h07, 1'b0, 9'h001);
        fifo_mem[10] = make_cmd(6'h3E, 3'd3, 3'd2, 6'h00, 6'h00, 1'b0, 9'h00A);
        fifo_mem[11] = make_cmd(6'h00, 3'd3, 3'd2, 6'h00, 6'h3F, 1'b0, 9'h00B);
        fifo_mem[12] = make_cmd(6'h00, 3'd3, 3'd3, 6'h15, 6'h3F, 1'b1, 9'h00C);
        #1 sysReset = 1'b0;
        tick; tick;

        // reset state
        chk("rst_count", 64'(count_a), 64'd0);
        chk("rst_empty", 64'(regempty_a), 64'd1);
        chk("rst_word", 64'(out_a), 64'd0);
        chk("rst_mask_mst", 64'(mst_a), 64'd0);
        force_a = 1'b0;
        #1;
        chk("rst_rd_en_gated", 64'(rd_en_a), 64'd0);
        sysReset = 1'b1;
        #1;
        chk("fill_rd_en0", 64'(rd_en_a), 64'd1);

        // fill to DEPTH
        tick;
        chk("fill_count1", 64'(count_a), 64'd1);
        chk("fill_empty", 64'(regempty_a), 64'd0);
        chk("fill_head0", 64'(out_a), 64'(fifo_mem[0]));
        chk("fill_rd_en1", 64'(rd_en_a), 64'd1);
        tick;
        chk("fill_count2", 64'(count_a), 64'd2);
        chk("fill_rd_en_full", 64'(rd_en_a), 64'd0);
        chk("dec_mask_mst", 64'(mst_a), 64'h1C);
        chk("dec_mask_slv", 64'(slv_a), 64'h3C);
        chk("dec_maddr_masked", 64'(masked_a), 64'h00);
        chk("dec_second", 64'(second_a), 64'h17);
        chk("dec_one_hot", 64'(onehot_a), 64'h04);
        chk("dec_eq", 64'(eq_a), 64'd1);
        chk("dec_scnt_p1", 64'(p1_a), 64'h08);
        chk("dec_smax_ext", 64'(smaxe_a), 64'h1C);

        // full stall
        tick; tick;
        chk("stall_count", 64'(count_a), 64'd2);
        chk("stall_head", 64'(out_a), 64'(fifo_mem[0]));
        chk("stall_rd_en", 64'(rd_en_a), 64'd0);
        chk("stall_fidx", 64'(fidx_a), 64'd2);

        // back-to-back streaming
        get_a = 1'b1;
        #1;
        for (int j = 0; j < 10; j++) begin
            chk("stream_rd_en", 64'(rd_en_a), 64'd1);
            chk("stream_count", 64'(count_a), 64'd2);
            chk("stream_head", 64'(out_a), 64'(fifo_mem[j]));
            tick;
        end
        get_a = 1'b0;
        #1;
        chk("wrap_head10", 64'(out_a), 64'(fifo_mem[10]));
        chk("wrap_second", 64'(second_a), 64'h02);
        chk("stream_fidx", 64'(fidx_a), 64'd12);

        get_a = 1'b1;
        tick;
        chk("wrap_head11", 64'(out_a), 64'(fifo_mem[11]));
        chk("wrap_scnt_p1", 64'(p1_a), 64'h00);
        chk("wrap_eq0", 64'(eq_a), 64'd0);
        tick;
        get_a = 1'b0;
        #1;
        chk("fixed_head12", 64'(out_a), 64'(fifo_mem[12]));
        chk("fixed_scnt_p1", 64'(p1_a), 64'h3F);
        chk("fixed_smax_ext", 64'(smaxe_a), 64'h28);
        chk("fixed_one_hot", 64'(onehot_a), 64'h08);
        chk("fixed_count", 64'(count_a), 64'd2);

        // flush with pop and FIFO non-empty
        flush_a = 1'b1;
        get_a = 1'b1;
        #1;
        chk("flush_rd_en", 64'(rd_en_a), 64'd0);
        tick;
        flush_a = 1'b0;
        get_a = 1'b0;
        #1;
        chk("flush_count", 64'(count_a), 64'd0);
        chk("flush_empty", 64'(regempty_a), 64'd1);
        chk("flush_fidx", 64'(fidx_a), 64'd14);
        chk("flush_head_kept", 64'(out_a), 64'(fifo_mem[12]));
        chk("flush_dec_kept", 64'(p1_a), 64'h3F);
        chk("post_flush_rd_en", 64'(rd_en_a), 64'd1);
        tick;
        chk("refill_count", 64'(count_a), 64'd1);
        chk("refill_head", 64'(out_a), 64'(fifo_mem[14]));

        // pop on empty queue
        force_a = 1'b1;
        get_a = 1'b1;
        tick;
        chk("drain_count", 64'(count_a), 64'd0);
        chk("drain_head_held", 64'(out_a), 64'(fifo_mem[14]));
        chk("drain_rd_en", 64'(rd_en_a), 64'd0);
        tick;
        chk("empty_pop_count", 64'(count_a), 64'd0);
        chk("empty_pop_empty", 64'(regempty_a), 64'd1);
        chk("empty_pop_head", 64'(out_a), 64'(fifo_mem[14]));
        chk("empty_pop_fidx", 64'(fidx_a), 64'd15);
        get_a = 1'b0;

        // reset mid-burst
        force_a = 1'b0;
        tick; tick;
        chk("pre_rst_count", 64'(count_a), 64'd2);
        chk("pre_rst_fidx", 64'(fidx_a), 64'd17);
        sysReset = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count_a), 64'd0);
        chk("mid_rst_empty", 64'(regempty_a), 64'd1);
        chk("mid_rst_rd_en", 64'(rd_en_a), 64'd0);
        chk("mid_rst_word", 64'(out_a), 64'd0);
        chk("mid_rst_mask", 64'(mst_a), 64'd0);
        tick;
        chk("mid_rst_fidx", 64'(fidx_a), 64'd17);
        force_a = 1'b1;
        sysReset = 1'b1;

        // DEPTH=1 instance
        force_b = 1'b0;
        #1;
        chk("d1_rd_en0", 64'(rd_en_b), 64'd1);
        tick;
        chk("d1_count", 64'(count_b), 64'd1);
        chk("d1_head0", 64'(out_b), 64'(fifo_mem[0]));
        chk("d1_rd_en_full", 64'(rd_en_b), 64'd0);
        chk("d1_mask_mst", 64'(mst_b), 64'h1C);
        chk("d1_mask_slv", 64'(slv_b), 64'h3C);
        chk("d1_maddr_masked", 64'(masked_b), 64'h00);
        chk("d1_second", 64'(second_b), 64'h17);
        chk("d1_one_hot", 64'(onehot_b), 64'h04);
        for (int k = 1; k < 4; k++) begin
            get_b = 1'b1;
            #1;
            chk("d1_rd_en_pop", 64'(rd_en_b), 64'd1);
            tick;
            chk("d1_head_pop", 64'(out_b), 64'(fifo_mem[k]));
            chk("d1_count_pop", 64'(count_b), 64'd1);
            get_b = 1'b0;
            #1;
            chk("d1_rd_en_hold", 64'(rd_en_b), 64'd0);
            tick;
            chk("d1_head_hold", 64'(out_b), 64'(fifo_mem[k]));
            chk("d1_fidx", 64'(fidx_b), 64'(k + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dwc_downconv_hold_queue_rd.md
Name: dwc_downconv_hold_queue_rd

Overview:
- Parametrised successor to the single-entry read-command holding register in the DWC down-converter read path.
- Sits between the read command FIFO (show-ahead) and the down-converter read control FSM.
- Buffers up to DEPTH commands and pre-decodes each command's address/size fields once, at load time, into registered side-band values.
- Adds occupancy reporting, a synchronous flush and parametrised address/field widths. The slave FSM can chain back-to-back bursts without a bubble.

Parameters:
- ID_WIDTH, 4, AXI ID width carried in the command word.
- CMD_FIFO_DATA_WIDTH, 37+ID_WIDTH, command word width.
- DEPTH, 2, queue entries (>=1; 1 reproduces single-register behaviour).
- ADDR_W, 6, low-address/size-decode width (log2 of widest data bus in bytes).
- MADDR_LSB, 23, LSB of master low address field (ADDR_W bits).
- MSIZE_LSB, 8, LSB of 3-bit master size.
- SSIZE_LSB, 11, LSB of 3-bit slave size.
- SMAX_LSB, 1, LSB of sizeMax field (ADDR_W bits).
- SCNT_LSB, 30+ID_WIDTH, LSB of sizeCnt field (ADDR_W bits).
- FIXED_BIT, 36+ID_WIDTH, FIXED-burst flag bit.

Ports:
- ACLK  in  1  clock.
- sysReset  in  1  asynchronous active-low reset.
- hold_data_in  in  CMD_FIFO_DATA_WIDTH  FIFO head word, valid when !hold_fifo_empty.
- hold_fifo_empty  in  1  command FIFO empty.
- hold_get_next_data  in  1  consumer pops current head.
- flush  in  1  synchronous discard of all entries.
- hold_fifo_rd_en  out  1  pop command FIFO this cycle.
- hold_data_out  out  CMD_FIFO_DATA_WIDTH  head command word.
- hold_reg_empty  out  1  queue empty.
- hold_count  out  $clog2(DEPTH+1)  occupancy.
- mask_mstSize  out  ADDR_W  ((1<<msize)-1) & ~((1<<ssize)-1).
- mask_slvSize  out  ADDR_W  ~((1<<ssize)-1).
- sizeCnt_comb_EQ_SizeMax  out  1  sizeCnt == sizeMax.
- master_ADDR_masked  out  ADDR_W  maddr & ~((1<<msize)-1).
- second_Beat_Addr  out  ADDR_W  maddr + (1<<ssize), modulo 2^ADDR_W.
- sizeCnt_comb_P1  out  ADDR_W  fixed ? sizeCnt : sizeCnt+1, modulo 2^ADDR_W.
- slaveSize_one_hot_hold  out  ADDR_W+1  1<<ssize.
- sizeMax_extend  out  ADDR_W  (sizeMax<<ssize), truncated.

Behaviour:
- Reset (sysReset low, asynchronous):
  - All storage, all decoded outputs and hold_count go to 0.
  - hold_reg_empty=1 and hold_fifo_rd_en=0.
- Decoded outputs:
  - Computed combinationally from hold_data_in and stored per entry alongside the word.
  - Outputs always reflect the head entry. With the queue empty they hold the last popped values and are don't-care.
- pop = hold_get_next_data & !hold_reg_empty. A pop on an empty queue is ignored; count stays 0.
- hold_fifo_rd_en = !hold_fifo_empty & !flush & (count<DEPTH | pop). Combinational; no registered stall bubble.
- Push = hold_fifo_rd_en. The word is captured at the tail on the same edge.
- Latency: a command popped from the FIFO in cycle N is visible at the head in cycle N+1 if the queue was empty or became empty in cycle N.
- Simultaneous push and pop: count unchanged and head advances. When full (count==DEPTH), push is allowed only with pop.
- Storage is a circular buffer with wr_ptr/rd_ptr wrapping at DEPTH. It must work for non-power-of-two DEPTH.
- Flush: next edge sets count=0 and pointers=0. Same-cycle pop and push are suppressed; decoded outputs are not cleared.
- Size fields must be <= ADDR_W. Shifts use ADDR_W+1 internal width, then truncate.
- Reset asserted mid-operation discards all entries; no FIFO pop occurs while sysReset is low.
- Invariant checked by assertion: 0 <= count <= DEPTH.

Decomposition:
- Package dwc_rd_cmd_pkg holds the field-offset defaults, ADDR_W default and a decoded-field struct/typedef. The struct covers the eight decoded values, 6*ADDR_W+ADDR_W+1+1 bits.
- One sub-module, dwc_rd_cmd_decode: purely combinational command word -> decoded struct, instantiated once on the input side.
- The queue itself stays in this module.

Test Plan:
- Reset then idle:
  - Stimulus: FIFO non-empty with msize=5, ssize=2, maddr=6'h13.
  - After 1 cycle: rd_en pulses once, and with DEPTH=2 pulses again next cycle. count 2.
  - Outputs: mask_mstSize=6'h1C, mask_slvSize=6'h3C, master_ADDR_masked=6'h00, second_Beat_Addr=6'h17, slaveSize_one_hot_hold=7'h04.
- Back-to-back streaming:
  - Stimulus: FIFO never empty, get_next held high for 10 cycles.
  - Required: rd_en high every cycle, count constant at DEPTH, head words appear in FIFO order with no gaps.
- Full stall: queue full and get_next=0 -> rd_en=0; count stays 2; head unchanged.
- Wrap arithmetic:
  - Case 1: maddr=6'h3E, ssize=2 -> second_Beat_Addr=6'h02.
  - Case 2: sizeCnt=6'h3F, fixed=0 -> sizeCnt_comb_P1=6'h00.
  - Case 3: fixed=1 -> sizeCnt_comb_P1=6'h3F.
  - Case 4: sizeCnt==sizeMax=6'h07 -> EQ=1.
- Flush/reset mid-operation:
  - Stimulus: count=2, flush with pop and FIFO non-empty.
  - Required: next cycle count=0, hold_reg_empty=1, rd_en=0 during the flush cycle.
  - Stimulus: sysReset low mid-burst. Required: immediate empty and rd_en=0.
- Empty pop and DEPTH=1 regression:
  - Stimulus: get_next on empty queue. Required: no change.
  - Stimulus: DEPTH=1 build with alternating push/pop. Required: single-entry ordering and same decode values as scenario 1.
